// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI SCLK sequencer.
package spi_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        RUN,
        TRAIL
    } state_t;

    // SelectMode encodings: bit 1 is CPOL, bit 0 is CPHA.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Idle level of SCLK for a mode.
    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Set when data is shifted on the leading edge and sampled on the trailing edge.
    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter that ticks when it reaches zero and auto-reloads.
module spi_half_period_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    localparam logic [DIV_W-1:0] One = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = run && (cnt_q == '0);

    // Explicit load wins over the reload that follows a tick.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick) begin
            cnt_d = reload_val;
        end else if (run) begin
            cnt_d = cnt_q - One;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_sequencer.sv
// SPI master timing engine: SCLK generation, frame bit counting and
// sample/shift strobes for all four SPI modes, on a single clock.
module spi_sclk_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CNT_W = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       SelectMode,
    input  logic [DIV_W-1:0] Div,
    input  logic [CNT_W-1:0] FrameLen,
    output logic             SCLK,
    output logic             Sample_Stb,
    output logic             Shift_Stb,
    output logic [CNT_W-1:0] Count,
    output logic             Busy,
    output logic             Done
);

    localparam logic [CNT_W-1:0] MaxLen  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W:0]   EdgeOne = (CNT_W + 1)'(1);
    localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W:0]   edge_q;
    logic             lead_half_q;
    logic             sclk_q;
    logic             sample_q;
    logic             shift_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;

    logic             tick;
    logic             start_ok;
    logic [CNT_W-1:0] len_eff;
    logic             lead_first;
    logic             lead_exit;
    logic             fire;
    logic [CNT_W:0]   edge_nxt;
    logic             last_edge;
    logic             is_sample;
    logic             is_shift;
    logic             tmr_run;
    logic             tmr_load;
    logic [DIV_W-1:0] tmr_load_val;

    assign start_ok = (state_q == IDLE) && Start && !Abort;
    assign len_eff  = ((FrameLen == '0) || (FrameLen > MaxLen)) ? MaxLen : FrameLen;

    // The first edge lands 2H cycles after Start, so LEAD spends one full
    // half-period and then H-1 more cycles; with Div=0 the second part is empty.
    assign lead_first = (state_q == LEAD) && tick && !lead_half_q && (div_q != '0);
    assign lead_exit  = (state_q == LEAD) && tick && (lead_half_q || (div_q == '0));

    // An SCLK edge is issued on leaving LEAD and on every half-period tick in RUN.
    assign fire      = lead_exit || ((state_q == RUN) && tick);
    assign edge_nxt  = edge_q + EdgeOne;
    assign last_edge = (edge_nxt == {len_q, 1'b0});
    // Odd edges are leading: CPHA=0 samples there, CPHA=1 samples on trailing.
    assign is_sample = edge_nxt[0] ^ cpha(mode_q);
    // With CPHA=0 the final trailing edge carries no shift: the frame is over.
    assign is_shift  = !is_sample && !(last_edge && !cpha(mode_q));

    assign tmr_run      = (state_q != IDLE);
    assign tmr_load     = start_ok || lead_first;
    assign tmr_load_val = (state_q == IDLE) ? Div : (div_q - DivOne);

    spi_half_period_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk        (clk),
        .Reset      (Reset),
        .run        (tmr_run),
        .load       (tmr_load),
        .load_val   (tmr_load_val),
        .reload_val (div_q),
        .tick       (tick)
    );

    // FSM, frame latches, edge counter and registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE0;
            div_q       <= '0;
            len_q       <= '0;
            edge_q      <= '0;
            lead_half_q <= 1'b0;
            sclk_q      <= 1'b0;
            sample_q    <= 1'b0;
            shift_q     <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            if (Abort && (state_q != IDLE)) begin
                // Count is left as-is so the controller can see how far it got.
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                lead_half_q <= 1'b0;
                sclk_q      <= cpol(mode_q);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        sclk_q <= cpol(SelectMode);
                        if (start_ok) begin
                            mode_q      <= SelectMode;
                            div_q       <= Div;
                            len_q       <= len_eff;
                            edge_q      <= '0;
                            count_q     <= '0;
                            lead_half_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= LEAD;
                        end
                    end
                    LEAD: begin
                        if (lead_first) begin
                            lead_half_q <= 1'b1;
                        end
                        if (lead_exit) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (fire && last_edge) begin
                            state_q <= TRAIL;
                        end
                    end
                    TRAIL: begin
                        // Done is raised for the last TRAIL cycle, then we leave.
                        if (done_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            sclk_q  <= cpol(mode_q);
                        end else if (tick) begin
                            done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase

                if (fire) begin
                    sclk_q   <= ~sclk_q;
                    edge_q   <= edge_nxt;
                    sample_q <= is_sample;
                    shift_q  <= is_shift;
                    if (is_sample && (count_q != len_q)) begin
                        count_q <= count_q + CntOne;
                    end
                end
            end
        end
    end

    assign SCLK       = sclk_q;
    assign Sample_Stb = sample_q;
    assign Shift_Stb  = shift_q;
    assign Count      = count_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_spi_sclk_sequencer.sv
// Directed bench for spi_sclk_sequencer. Cycle 0 is the cycle whose closing
// edge samples Start; cycle c values are sampled at the falling edge inside c.
module tb_spi_sclk_sequencer;
    import spi_pkg::*;

    localparam int DATA_W = 16;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = 5;
    localparam int MAXC   = 80;

    logic             clk = 1'b0;
    logic             Reset = 1'b0;
    logic             Start = 1'b0;
    logic             Abort = 1'b0;
    logic [1:0]       SelectMode = MODE0;
    logic [DIV_W-1:0] Div = '0;
    logic [CNT_W-1:0] FrameLen = '0;
    logic             SCLK;
    logic             Sample_Stb;
    logic             Shift_Stb;
    logic [CNT_W-1:0] Count;
    logic             Busy;
    logic             Done;

    int total = 0;
    int bad = 0;

    logic             r_sclk [0:MAXC];
    logic             r_smp  [0:MAXC];
    logic             r_shf  [0:MAXC];
    logic             r_busy [0:MAXC];
    logic             r_done [0:MAXC];
    logic [CNT_W-1:0] r_cnt  [0:MAXC];

    spi_sclk_sequencer #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Abort      (Abort),
        .SelectMode (SelectMode),
        .Div        (Div),
        .FrameLen   (FrameLen),
        .SCLK       (SCLK),
        .Sample_Stb (Sample_Stb),
        .Shift_Stb  (Shift_Stb),
        .Count      (Count),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    // Timing model: edge k at cycle h*(k+1), Done at h*(2n+2).
    // Packed as {SCLK, Sample, Shift, Busy, Done, Count}.
    function automatic logic [9:0] exp_vec(input int c, input logic [1:0] m,
                                           input int h, input int n);
        int ne;
        int k;
        int cnt;
        logic smp, shf, dn, bsy, sck;
        ne = 0;
        for (int j = 1; j <= 2 * n; j++) if (h * (j + 1) <= c) ne = j;
        k = ((c % h) == 0) ? (c / h - 1) : 0;
        smp = 1'b0;
        shf = 1'b0;
        if (k >= 1 && k <= 2 * n) begin
            if (((k % 2) == 1) == (m[0] == 1'b0)) smp = 1'b1;
            else if (!(m[0] == 1'b0 && k == 2 * n)) shf = 1'b1;
        end
        dn  = (c == h * (2 * n + 2));
        bsy = (c >= 1) && (c <= h * (2 * n + 2));
        sck = bsy ? (m[1] ^ ne[0]) : m[1];
        cnt = m[0] ? ne / 2 : (ne + 1) / 2;
        return {sck, smp, shf, bsy, dn, cnt[4:0]};
    endfunction

    task automatic start_frame(input logic [1:0] m, input int d, input int len);
        @(negedge clk);
        SelectMode = m;
        Div = DIV_W'(d);
        FrameLen = CNT_W'(len);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic capture(input int from, input int to);
        for (int c = from; c <= to; c++) begin
            @(negedge clk);
            r_sclk[c] = SCLK;
            r_smp[c]  = Sample_Stb;
            r_shf[c]  = Shift_Stb;
            r_busy[c] = Busy;
            r_done[c] = Done;
            r_cnt[c]  = Count;
        end
    endtask

    task automatic test_reset;
        SelectMode = MODE2;
        #1;
        total++;
        if ({SCLK, Sample_Stb, Shift_Stb, Busy, Done, Count} !== 10'b0) begin
            bad++;
            $display("FAIL reset_vals got=%b exp=%b",
                     {SCLK, Sample_Stb, Shift_Stb, Busy, Done, Count}, 10'b0);
        end
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        total++;
        if (SCLK !== 1'b1) begin
            bad++;
            $display("FAIL reset_cpol_track got=%b exp=1", SCLK);
        end
        SelectMode = MODE0;
        @(negedge clk);
        total++;
        if (SCLK !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_follow got sclk=%b busy=%b exp 0 0", SCLK, Busy);
        end
    endtask

    task automatic test_mode0;
        int ns, nh;
        logic [9:0] act, exp;
        start_frame(MODE0, 0, 0);
        capture(1, 36);
        ns = 0;
        nh = 0;
        for (int c = 1; c <= 36; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE0, 1, 16);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL mode0 cyc=%0d got=%b exp=%b", c, act, exp);
            end
            ns += int'(r_smp[c]);
            nh += int'(r_shf[c]);
        end
        total++;
        if (ns != 16 || nh != 15) begin
            bad++;
            $display("FAIL mode0_strobes got smp=%0d shf=%0d exp 16 15", ns, nh);
        end
        total++;
        if (r_done[34] !== 1'b1 || r_cnt[34] !== 5'd16) begin
            bad++;
            $display("FAIL mode0_done got done=%b cnt=%0d exp 1 16", r_done[34], r_cnt[34]);
        end
    endtask

    task automatic test_mode3;
        logic [9:0] act, exp;
        start_frame(MODE3, 3, 8);
        capture(1, 74);
        for (int c = 1; c <= 74; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE3, 4, 8);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL mode3 cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
        total++;
        if (r_sclk[7] !== 1'b1 || r_sclk[8] !== 1'b0 || r_shf[8] !== 1'b1 || r_smp[8] !== 1'b0)
        begin
            bad++;
            $display("FAIL mode3_first_edge got sclk7=%b sclk8=%b shf=%b smp=%b exp 1 0 1 0",
                     r_sclk[7], r_sclk[8], r_shf[8], r_smp[8]);
        end
        total++;
        if (r_done[72] !== 1'b1 || r_cnt[72] !== 5'd8) begin
            bad++;
            $display("FAIL mode3_done got done=%b cnt=%0d exp 1 8", r_done[72], r_cnt[72]);
        end
    endtask

    task automatic test_mode1;
        logic [9:0] act, exp;
        start_frame(MODE1, 1, 1);
        capture(1, 10);
        for (int c = 1; c <= 10; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE1, 2, 1);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL mode1 cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
        total++;
        if (r_shf[4] !== 1'b1 || r_smp[6] !== 1'b1 || r_done[8] !== 1'b1) begin
            bad++;
            $display("FAIL mode1_edges got shf4=%b smp6=%b done8=%b exp 1 1 1",
                     r_shf[4], r_smp[6], r_done[8]);
        end
    endtask

    task automatic test_len_clamp;
        logic [9:0] act, exp;
        start_frame(MODE1, 0, 20);
        capture(1, 36);
        for (int c = 1; c <= 36; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE1, 1, 16);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL clamp cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
    endtask

    task automatic test_abort;
        logic [9:0] act, exp;
        int n;
        start_frame(MODE2, 0, 8);
        capture(1, 10);
        for (int c = 1; c <= 10; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE2, 1, 8);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL abort_pre cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
        Abort = 1'b1;
        @(posedge clk);
        #1;
        Abort = 1'b0;
        @(negedge clk);
        act = {SCLK, Sample_Stb, Shift_Stb, Busy, Done, Count};
        total++;
        if (act !== 10'b1_0_0_0_0_00101) begin
            bad++;
            $display("FAIL abort_after got=%b exp=%b", act, 10'b1_0_0_0_0_00101);
        end
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(negedge clk);
        total++;
        if (Busy !== 1'b1 || Count !== 5'd0 || SCLK !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart got busy=%b cnt=%0d sclk=%b exp 1 0 1",
                     Busy, Count, SCLK);
        end
        n = 0;
        while (Done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 17 || Count !== 5'd8) begin
            bad++;
            $display("FAIL abort_refr_done got wait=%0d cnt=%0d exp 17 8", n, Count);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] act, exp;
        @(negedge clk);
        SelectMode = MODE0;
        Div = '0;
        FrameLen = CNT_W'(2);
        Start = 1'b1;
        @(posedge clk);
        capture(1, 8);
        Start = 1'b0;
        capture(9, 16);
        for (int c = 1; c <= 16; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = (c <= 7) ? exp_vec(c, MODE0, 1, 2) : exp_vec(c - 7, MODE0, 1, 2);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
    endtask

    task automatic test_mode_change;
        logic [9:0] act, exp;
        start_frame(MODE0, 0, 2);
        capture(1, 2);
        SelectMode = MODE3;
        Div = DIV_W'(5);
        FrameLen = CNT_W'(7);
        capture(3, 9);
        for (int c = 1; c <= 6; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE0, 1, 2);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL modechg cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
        total++;
        if (r_sclk[8] !== 1'b1 || r_sclk[9] !== 1'b1 || r_busy[8] !== 1'b0) begin
            bad++;
            $display("FAIL modechg_idle got sclk8=%b sclk9=%b busy8=%b exp 1 1 0",
                     r_sclk[8], r_sclk[9], r_busy[8]);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] act, exp;
        start_frame(MODE0, 2, 4);
        capture(1, 7);
        for (int c = 1; c <= 7; c++) begin
            act = {r_sclk[c], r_smp[c], r_shf[c], r_busy[c], r_done[c], r_cnt[c]};
            exp = exp_vec(c, MODE0, 3, 4);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", c, act, exp);
            end
        end
        Reset = 1'b0;
        #1;
        act = {SCLK, Sample_Stb, Shift_Stb, Busy, Done, Count};
        total++;
        if (act !== 10'b0) begin
            bad++;
            $display("FAIL rstmid_async got=%b exp=%b", act, 10'b0);
        end
        @(negedge clk);
        @(negedge clk);
        act = {SCLK, Sample_Stb, Shift_Stb, Busy, Done, Count};
        total++;
        if (act !== 10'b0) begin
            bad++;
            $display("FAIL rstmid_hold got=%b exp=%b", act, 10'b0);
        end
        Reset = 1'b1;
        capture(1, 3);
        total++;
        if (r_busy[3] !== 1'b0 || r_done[3] !== 1'b0 || r_done[1] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after got busy=%b done=%b exp 0 0", r_busy[3], r_done[3]);
        end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_mode1;
        test_len_clamp;
        test_abort;
        test_back_to_back;
        test_mode_change;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
